fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC, drives a req/ack instruction-memory port and writes the IF/ID pipeline register that feeds decode (main_control, hazard detection). It obeys the 3-bit stall vector from hazard detection and takes branch/jump redirects from downstream. Memory latency may be zero or more cycles. A one-entry hold buffer keeps fetched words that cannot enter IF/ID during a stall.

---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage_if_id_reg.sv | 62 ++++++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared pipeline definitions for the instruction-fetch stage.
//   - Bit positions inside the 3-bit stall vector from hazard detection
//   - The encoding used for an empty (bubble) IF/ID slot
//   - The fetch FSM state type
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    // Bit positions inside the hazard-detection stall vector
    localparam int STALL_PCW    = 2;
    localparam int STALL_IFIDW  = 1;
    localparam int STALL_BUBBLE = 0;

    // Instruction word placed in IF/ID when it carries a bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Sequential fetch advances one 32-bit word at a time
    localparam logic [31:0] PC_STEP = 32'd4;

    // FETCH: request at pc; HOLD: word parked in hold buffer, no request;
    // DROP: finishing an abandoned request whose response is thrown away
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory req/ack port between the fetch stage and memory.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : word-aligned fetch address (master -> slave)
//   imem_ack   : response valid, may come in the same cycle as the request
//   imem_rdata : instruction word, valid while imem_ack=1
// The fetch stage uses the master modport, the memory the slave modport.
// -----------------------------------------------------------------------------
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register: valid flag, instruction word and PC+4, plus the
// opcode/rs/rt fields decode needs early for control and hazard detection.
//   clk, rst   : clock and synchronous active-high reset
//   i_we       : load {1, i_instr, i_pc4}
//   i_flush    : load a bubble {0, NOP, 0}; wins over i_we
//   i_instr    : incoming instruction word
//   i_pc4      : incoming PC+4
//   o_valid    : register holds a real instruction
//   o_instr    : registered instruction (NOP when not valid)
//   o_pc4      : registered PC+4
//   o_opcode/o_rs/o_rt : fields [31:26]/[25:21]/[20:16] of o_instr
// -----------------------------------------------------------------------------
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;

    // Flush beats write so a redirect can never let a wrong-path word in;
    // with neither asserted the register simply holds (stall freeze).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
        end else if (i_we) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end
    end

    // Field slicing is purely combinational off the registered word
    assign o_valid  = r_valid;
    assign o_instr  = r_instr;
    assign o_pc4    = r_pc4;
    assign o_opcode = r_instr[31:26];
    assign o_rs     = r_instr[25:21];
    assign o_rt     = r_instr[20:16];

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC,
// drives the instruction-memory req/ack port, and writes IF/ID. Honours the
// hazard stall vector, takes beq/j redirects from downstream, and parks a
// fetched word in a one-entry hold buffer when IF/ID cannot take it.
//   clk, rst        : clock and synchronous active-high reset
//   stall[2:0]      : [2] pc_write, [1] if_id_write, [0] bubble (unused here)
//   redirect_valid  : taken branch / jump resolved downstream
//   redirect_pc     : redirect target, low two bits ignored
//   imem            : instruction-memory port (master side)
//   if_id_valid     : IF/ID holds a real instruction
//   if_id_instr     : IF/ID instruction (0 when invalid)
//   if_id_pc4       : IF/ID PC+4
//   if_id_opcode/rs/rt : decoded fields of if_id_instr
//   fetch_busy      : FSM is not in FETCH
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    fetch_stage_if.master      imem,
    output logic               if_id_valid,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic [5:0]         if_id_opcode,
    output logic [4:0]         if_id_rs,
    output logic [4:0]         if_id_rt,
    output logic               fetch_busy
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_hold;
    logic [31:0]  r_dropAddr;

    logic         w_accept;
    logic         w_ifIdW;
    logic [31:0]  w_pc4;
    logic [31:0]  w_redirTarget;
    logic         w_ifIdWe;
    logic         w_ifIdFlush;
    logic [31:0]  w_ifIdInstr;
    logic         w_unusedBubble;

    // A word may only enter IF/ID when both PC and IF/ID are allowed to move
    assign w_accept       = stall[STALL_PCW] & stall[STALL_IFIDW];
    assign w_ifIdW        = stall[STALL_IFIDW];
    assign w_pc4          = r_pc + PC_STEP;
    assign w_redirTarget  = redirect_pc & 32'hFFFF_FFFC;
    assign w_unusedBubble = stall[STALL_BUBBLE];

    // Request and address come only from registered state and rst, so there
    // is no combinational path from the memory response back to the request.
    assign imem.imem_req  = ~rst & (r_state != HOLD);
    assign imem.imem_addr = (r_state == DROP) ? r_dropAddr : r_pc;
    assign fetch_busy     = (r_state != FETCH);

    // IF/ID write control. A redirect flushes regardless of stall; otherwise
    // a word is written when accepted, and an empty cycle becomes a bubble
    // only when IF/ID is allowed to change.
    always_comb begin
        w_ifIdWe    = 1'b0;
        w_ifIdFlush = 1'b0;
        w_ifIdInstr = imem.imem_rdata;
        if (redirect_valid) begin
            w_ifIdFlush = 1'b1;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        w_ifIdWe = w_accept;
                    end else begin
                        w_ifIdFlush = w_ifIdW;
                    end
                end
                HOLD: begin
                    w_ifIdWe    = w_accept;
                    w_ifIdInstr = r_hold;
                end
                DROP: begin
                    w_ifIdFlush = w_ifIdW;
                end
                default: begin
                    w_ifIdFlush = 1'b0;
                end
            endcase
        end
    end

    // Fetch FSM, PC, hold buffer and drop address. An outstanding request
    // cannot be withdrawn, so a redirect during a wait moves into DROP and
    // lets the old address complete; later redirects only retarget pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_hold     <= NOP_INSTR;
            r_dropAddr <= 32'd0;
        end else if (redirect_valid) begin
            r_pc   <= w_redirTarget;
            r_hold <= NOP_INSTR;
            case (r_state)
                FETCH: begin
                    if (!imem.imem_ack) begin
                        r_dropAddr <= r_pc;
                        r_state    <= DROP;
                    end
                end
                HOLD:    r_state <= FETCH;
                DROP:    r_state <= DROP;
                default: r_state <= FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        if (w_accept) begin
                            r_pc <= w_pc4;
                        end else begin
                            r_hold  <= imem.imem_rdata;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_pc    <= w_pc4;
                        r_state <= FETCH;
                    end
                end
                DROP: begin
                    if (imem.imem_ack) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    if_id_reg u_ifIdReg (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_ifIdWe),
        .i_flush  (w_ifIdFlush),
        .i_instr  (w_ifIdInstr),
        .i_pc4    (w_pc4),
        .o_valid  (if_id_valid),
        .o_instr  (if_id_instr),
        .o_pc4    (if_id_pc4),
        .o_opcode (if_id_opcode),
        .o_rs     (if_id_rs),
        .o_rt     (if_id_rt)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed, table-driven bench for fetch_stage. Each table row gives the
// inputs for one cycle and the outputs expected just after that cycle's edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    typedef struct {
        string       name;
        logic [2:0]  stall;
        logic        rv;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc4;
        logic        eBusy;
    } vec_t;

    localparam int NVEC = 21;

    localparam logic [31:0] I0 = 32'h2001_0001;
    localparam logic [31:0] I1 = 32'h2002_0002;
    localparam logic [31:0] LW = 32'h8C01_0004;
    localparam logic [31:0] I3 = 32'h0000_0020;
    localparam logic [31:0] I4 = 32'h0800_0010;
    localparam logic [31:0] I5 = 32'h1000_FFFF;
    localparam logic [31:0] I6 = 32'h2403_0007;
    localparam logic [31:0] I7 = 32'h2404_0009;
    localparam logic [31:0] I8 = 32'h8C02_0008;
    localparam logic [31:0] I9 = 32'h3C05_1234;

    logic        clk;
    logic        rst;
    logic [2:0]  stall;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        ifIdValid;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPc4;
    logic [5:0]  ifIdOpcode;
    logic [4:0]  ifIdRs;
    logic [4:0]  ifIdRt;
    logic        fetchBusy;

    int checkCount = 0;
    int errorCount = 0;

    vec_t vecs[NVEC];

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .imem           (imem.master),
        .if_id_valid    (ifIdValid),
        .if_id_instr    (ifIdInstr),
        .if_id_pc4      (ifIdPc4),
        .if_id_opcode   (ifIdOpcode),
        .if_id_rs       (ifIdRs),
        .if_id_rt       (ifIdRt),
        .fetch_busy     (fetchBusy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever fails to complete
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(string n, logic [2:0] s, logic rv, logic [31:0] rpc,
                                   logic ack, logic [31:0] rd, logic eReq, logic [31:0] eAddr,
                                   logic eValid, logic [31:0] eInstr, logic [31:0] ePc4,
                                   logic eBusy);
        vec_t v;
        v.name = n; v.stall = s; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdata = rd;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.eInstr = eInstr;
        v.ePc4 = ePc4; v.eBusy = eBusy;
        return v;
    endfunction

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(vec_t v);
        checkVal({v.name, ".req"},    {31'd0, imem.imem_req}, {31'd0, v.eReq});
        checkVal({v.name, ".addr"},   imem.imem_addr, v.eAddr);
        checkVal({v.name, ".valid"},  {31'd0, ifIdValid}, {31'd0, v.eValid});
        checkVal({v.name, ".instr"},  ifIdInstr, v.eInstr);
        checkVal({v.name, ".pc4"},    ifIdPc4, v.ePc4);
        checkVal({v.name, ".busy"},   {31'd0, fetchBusy}, {31'd0, v.eBusy});
        checkVal({v.name, ".fields"}, {16'd0, ifIdOpcode, ifIdRs, ifIdRt},
                 {16'd0, v.eInstr[31:26], v.eInstr[25:21], v.eInstr[20:16]});
    endtask

    // Drive one cycle's inputs at the falling edge, then check just after
    // the rising edge that consumes them.
    task automatic applyStimulus(vec_t v);
        @(negedge clk);
        stall           = v.stall;
        redirectValid   = v.rv;
        redirectPc      = v.rpc;
        imem.imem_ack   = v.ack;
        imem.imem_rdata = v.rdata;
        @(posedge clk);
        #1;
        checkOutput(v);
    endtask

    initial begin
        vecs[0]  = mkVec("run0",          3'b110, 0, 32'h0,         1, I0,           1, 32'h4,         1, I0, 32'h4,   0);
        vecs[1]  = mkVec("run1",          3'b110, 0, 32'h0,         1, I1,           1, 32'h8,         1, I1, 32'h8,   0);
        vecs[2]  = mkVec("loadUseStall",  3'b001, 0, 32'h0,         1, LW,           0, 32'h8,         1, I1, 32'h8,   1);
        vecs[3]  = mkVec("holdRelease",   3'b110, 0, 32'h0,         0, 32'h0,        1, 32'hC,         1, LW, 32'hC,   0);
        vecs[4]  = mkVec("waitBubble",    3'b110, 0, 32'h0,         0, 32'h0,        1, 32'hC,         0, 0,  32'h0,   0);
        vecs[5]  = mkVec("fetch12",       3'b110, 0, 32'h0,         1, I3,           1, 32'h10,        1, I3, 32'h10,  0);
        vecs[6]  = mkVec("wait16",        3'b110, 0, 32'h0,         0, 32'h0,        1, 32'h10,        0, 0,  32'h0,   0);
        vecs[7]  = mkVec("redirInWait",   3'b110, 1, 32'h43,        0, 32'h0,        1, 32'h10,        0, 0,  32'h0,   1);
        vecs[8]  = mkVec("dropAck",       3'b110, 0, 32'h0,         1, 32'hDEADBEEF, 1, 32'h40,        0, 0,  32'h0,   0);
        vecs[9]  = mkVec("fetch40",       3'b110, 0, 32'h0,         1, I4,           1, 32'h44,        1, I4, 32'h44,  0);
        vecs[10] = mkVec("redirWithStall",3'b001, 1, 32'h80,        1, 32'h11111111, 1, 32'h80,        0, 0,  32'h0,   0);
        vecs[11] = mkVec("redirTo100",    3'b110, 1, 32'h100,       0, 32'h0,        1, 32'h80,        0, 0,  32'h0,   1);
        vecs[12] = mkVec("redirTo200",    3'b110, 1, 32'h200,       0, 32'h0,        1, 32'h80,        0, 0,  32'h0,   1);
        vecs[13] = mkVec("dropAck2",      3'b110, 0, 32'h0,         1, 32'hBAD0BAD0, 1, 32'h200,       0, 0,  32'h0,   0);
        vecs[14] = mkVec("fetch200",      3'b110, 0, 32'h0,         1, I5,           1, 32'h204,       1, I5, 32'h204, 0);
        vecs[15] = mkVec("redirTop",      3'b110, 1, 32'hFFFFFFFF,  1, 32'h55555555, 1, 32'hFFFFFFFC,  0, 0,  32'h0,   0);
        vecs[16] = mkVec("wrapFetch",     3'b110, 0, 32'h0,         1, I6,           1, 32'h0,         1, I6, 32'h0,   0);
        vecs[17] = mkVec("freezeNoAck",   3'b000, 0, 32'h0,         0, 32'h0,        1, 32'h0,         1, I6, 32'h0,   0);
        vecs[18] = mkVec("fetch0",        3'b110, 0, 32'h0,         1, I7,           1, 32'h4,         1, I7, 32'h4,   0);
        vecs[19] = mkVec("stallHold",     3'b001, 0, 32'h0,         1, I8,           0, 32'h4,         1, I7, 32'h4,   1);
        vecs[20] = mkVec("holdStay",      3'b001, 0, 32'h0,         0, 32'h0,        0, 32'h4,         1, I7, 32'h4,   1);

        rst             = 1'b1;
        stall           = 3'b110;
        redirectValid   = 1'b0;
        redirectPc      = 32'h0;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'h0;

        // Reset state: request held low while rst is high, IF/ID empty
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset.req",   {31'd0, imem.imem_req}, 32'd0);
        checkVal("reset.valid", {31'd0, ifIdValid}, 32'd0);
        checkVal("reset.instr", ifIdInstr, 32'h0);
        checkVal("reset.pc4",   ifIdPc4, 32'h0);
        checkVal("reset.busy",  {31'd0, fetchBusy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("reset.reqAfter",  {31'd0, imem.imem_req}, 32'd1);
        checkVal("reset.addrAfter", imem.imem_addr, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of HOLD: everything returns to reset values and
        // the parked word must not reappear after restart.
        @(negedge clk);
        rst           = 1'b1;
        stall         = 3'b110;
        imem.imem_ack = 1'b0;
        @(posedge clk);
        #1;
        checkVal("midHoldRst.req",   {31'd0, imem.imem_req}, 32'd0);
        checkVal("midHoldRst.valid", {31'd0, ifIdValid}, 32'd0);
        checkVal("midHoldRst.instr", ifIdInstr, 32'h0);
        checkVal("midHoldRst.pc4",   ifIdPc4, 32'h0);
        checkVal("midHoldRst.busy",  {31'd0, fetchBusy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("midHoldRst.restartReq",  {31'd0, imem.imem_req}, 32'd1);
        checkVal("midHoldRst.restartAddr", imem.imem_addr, 32'h0);
        applyStimulus(mkVec("afterRst", 3'b110, 0, 32'h0, 1, I9, 1, 32'h4, 1, I9, 32'h4, 0));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
